cacheline_arbiter: RTL

Shares the single 256-bit cacheline memory port between the instruction cache and the data cache. Each requester issues a line read or write and holds it until it receives a one-cycle response. The arbiter grants one requester at a time, round-robin, and drives the memory port from registered, stable copies of the granted request. It sits between the two cache miss-handling FSMs and the memory interface, `mem_itf`, so the memory model's protocol checks never fire.

---
 rtl/cacheline_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between I-cache and D-cache.
// The granted request is latched and held on the memory port until mem_resp.
module cacheline_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned OFFS_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

    logic [1:0]        state_q, state_d;
    logic              own_q, own_d;
    logic              last_q, last_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;

    logic              i_pend_c, d_pend_c, gnt_c;
    logic              sel_rd_c, sel_wr_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [LINE_W-1:0] sel_wdata_c;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            own_q       <= SIDE_I;
            last_q      <= SIDE_D;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_resp_q    <= i_resp_d;
            d_resp_q    <= d_resp_d;
        end
    end

    // Arbitration, next-state and next-output logic
    always_comb begin
        i_pend_c    = i_read | i_write;
        d_pend_c    = d_read | d_write;
        gnt_c       = (i_pend_c && d_pend_c) ? ~last_q : d_pend_c;
        sel_wr_c    = gnt_c ? d_write : i_write;
        sel_rd_c    = (gnt_c ? d_read : i_read) & ~sel_wr_c;
        sel_addr_c  = gnt_c ? d_addr : i_addr;
        sel_wdata_c = gnt_c ? d_wdata : i_wdata;

        state_d     = state_q;
        own_d       = own_q;
        last_d      = last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_resp_d    = 1'b0;
        d_resp_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_pend_c || d_pend_c) begin
                    mem_read_d  = sel_rd_c;
                    mem_write_d = sel_wr_c;
                    mem_addr_d  = sel_addr_c & LINE_MASK;
                    mem_wdata_d = sel_wdata_c;
                    own_d       = gnt_c;
                    last_d      = gnt_c;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    // Write completions leave the owner's read data untouched
                    if (mem_read_q) begin
                        if (own_q == SIDE_D) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            i_rdata_d = mem_rdata;
                        end
                    end
                    i_resp_d = (own_q == SIDE_I);
                    d_resp_d = (own_q == SIDE_D);
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_resp    = i_resp_q;
    assign d_resp    = d_resp_q;

endmodule
